data_cache: RTL and testbench
=============================

# data_cache

Direct-mapped, write-back, write-allocate data cache between the pipeline's MEM stage and a multi-cycle backing memory. On a hit it returns load data combinationally in the request cycle. On a miss it asserts a stall until the line is refilled, writing back a dirty victim first. The EX/MEM stage holds its request stable while stalled, and the cache keeps hit and miss counters for performance reporting.

## Interface
- NUM_LINES, 16, number of lines (power of two, ≥2)
- LINE_WORDS, 4, 32-bit words per line (fixed 4; line = 128 bits)
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- is_input_valid  input  1  CPU request present (EX_MEM_mem_read | EX_MEM_mem_write)
- addr  input  32  byte address, word aligned; [3:2] word offset, [3+log2(NUM_LINES):4] index, rest tag
- mem_rw  input  1  0 = load, 1 = store
- din  input  32  store data
- is_ready  output  1  cache can accept/resolve a request (state IDLE)
- is_output_valid  output  1  request completes this cycle
- dout  output  32  load data; 0 when is_output_valid=0
- is_hit  output  1  valid request hits in IDLE
- mem_req_valid  output  1  backing memory request
- mem_req_write  output  1  1 = line write-back, 0 = line read
- mem_req_addr  output  32  line-aligned address ([3:0]=0)
- mem_req_data  output  128  write-back line data
- mem_req_ready  input  1  backing memory accepts request this cycle
- mem_resp_valid  input  1  read line data valid (one cycle pulse)
- mem_resp_data  input  128  refilled line
- hit_count  output  32  completed hits since reset
- miss_count  output  32  misses since reset

## Operation
- Per line: valid, dirty, tag, 128-bit data.
- States: IDLE, WRITEBACK, ALLOCATE, REFILL_WAIT.
- IDLE: is_ready=1. Hit = is_input_valid & valid[idx] & tag match.
  - On a hit, is_hit=1 and is_output_valid=1.
  - A load hit drives dout = selected word.
  - A store hit writes din into the word at the clock edge and sets dirty.
  - hit_count increments.
- IDLE miss (is_input_valid & ~hit):
  - Outputs: is_output_valid=0, is_hit=0.
  - miss_count increments.
  - Next state is WRITEBACK if the victim is valid & dirty, else ALLOCATE.
- WRITEBACK:
  - Drives mem_req_valid=1, mem_req_write=1, mem_req_addr={victim tag, idx, 4'b0}, mem_req_data=victim line.
  - Stays until mem_req_ready=1, then goes to ALLOCATE.
- ALLOCATE:
  - Drives mem_req_valid=1, mem_req_write=0, mem_req_addr={addr[31:4], 4'b0}.
  - Goes to REFILL_WAIT on mem_req_ready.
- REFILL_WAIT:
  - No request is driven.
  - On mem_resp_valid: line data ← mem_resp_data, tag ← addr tag, valid=1, dirty=0, then IDLE.
  - The held request then hits in IDLE and is counted as a hit; a miss thus adds one miss and one hit.
- mem_req_valid stays asserted with stable addr/data until mem_req_ready.
- is_ready=0 in every non-IDLE state; the pipeline stalls while ~is_output_valid & is_input_valid.
- Counters wrap modulo 2^32.

## Timing
- Reset (async):
  - State → IDLE; all valid and dirty bits → 0; counters → 0.
  - mem_req_valid=0, is_output_valid=0, dout=0, is_hit=0, is_ready=1.
  - Tags and data are don't-care.
- Reset mid-miss aborts the transaction: the request is dropped and any pending mem_resp_valid is ignored.
- Hit latency 0 cycles; the result appears in the request cycle.
- Clean miss, with mem_req_ready high in the ALLOCATE cycle and response N cycles after acceptance: miss cycle, ALLOCATE, N REFILL_WAIT cycles, hit cycle = N+3 cycles to is_output_valid.
- Dirty miss adds ≥1 WRITEBACK cycle, plus one more per cycle mem_req_ready is low.
- mem_resp_valid outside REFILL_WAIT is ignored.
- Request inputs change only after is_output_valid; a change while stalled is undefined.
- is_input_valid=0 in IDLE: no state or counter change.
- Back-to-back hits complete one per cycle.
- A store hit followed by a load of the same word in the next cycle returns the new data.

## Test plan
- Reset then idle:
  - is_ready=1, mem_req_valid=0, counters 0.
  - Load 0x0000_0040 → miss.
  - ALLOCATE drives addr 0x0000_0040 with mem_req_write=0.
  - Respond {w3..w0}={4,3,2,1} after 3 cycles → dout=1 at cycle 6; miss_count=1, hit_count=1.
- Load 0x44, 0x48, 0x4C back-to-back after the refill:
  - Hit each cycle, dout=2, 3, 4.
  - No memory requests; hit_count +3.
- Store 0xDEADBEEF to 0x48 (hit), then load 0x48:
  - Returns 0xDEADBEEF next cycle; the line becomes dirty.
- Load 0x0000_0140 (same index 4, different tag):
  - WRITEBACK drives addr 0x40, data {4, 0xDEADBEEF, 2, 1}.
  - Hold mem_req_ready low 2 cycles: request stays stable.
  - ALLOCATE then drives 0x140.
- Assert reset during REFILL_WAIT, then pulse mem_resp_valid:
  - Response ignored, state IDLE, counters 0.
  - Load 0x40 misses again (valid cleared).
- Counter wrap: preload hit_count via force to 0xFFFF_FFFF, then one hit → 0.

Source files
------------

// File: rtl/data_cache_if.sv
// Bus bundle for data_cache: pipeline request/response plus the backing-memory line port.
// The slave modport is the cache's view; master is the pipeline and memory around it.
interface data_cache_if;
  logic         is_input_valid;
  logic [31:0]  addr;
  logic         mem_rw;
  logic [31:0]  din;
  logic         is_ready;
  logic         is_output_valid;
  logic [31:0]  dout;
  logic         is_hit;

  logic         mem_req_valid;
  logic         mem_req_write;
  logic [31:0]  mem_req_addr;
  logic [127:0] mem_req_data;
  logic         mem_req_ready;
  logic         mem_resp_valid;
  logic [127:0] mem_resp_data;

  modport slave (
    input  is_input_valid, addr, mem_rw, din,
    input  mem_req_ready, mem_resp_valid, mem_resp_data,
    output is_ready, is_output_valid, dout, is_hit,
    output mem_req_valid, mem_req_write, mem_req_addr, mem_req_data
  );

  modport master (
    output is_input_valid, addr, mem_rw, din,
    output mem_req_ready, mem_resp_valid, mem_resp_data,
    input  is_ready, is_output_valid, dout, is_hit,
    input  mem_req_valid, mem_req_write, mem_req_addr, mem_req_data
  );
endinterface

// File: rtl/data_cache.sv
// Direct-mapped, write-back, write-allocate data cache for the MEM stage. Hits resolve
// combinationally in the request cycle; misses stall through write-back and refill.
module data_cache #(
  parameter int NUM_LINES  = 16,
  parameter int LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        reset,
  data_cache_if.slave bus,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);
  localparam int IDX_W     = $clog2(NUM_LINES);
  localparam int TAG_W     = 28 - IDX_W;
  localparam int LINE_BITS = LINE_WORDS * 32;

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    ALLOCATE,
    REFILL_WAIT
  } state_t;

  state_t state;
  state_t state_next;

  logic [NUM_LINES-1:0] valid;
  logic [NUM_LINES-1:0] dirty;
  logic [TAG_W-1:0]     tags  [NUM_LINES];
  logic [LINE_BITS-1:0] lines [NUM_LINES];

  logic [IDX_W-1:0]     idx;
  logic [TAG_W-1:0]     tag;
  logic [1:0]           offset;
  logic [LINE_BITS-1:0] line;
  logic [TAG_W-1:0]     line_tag;
  logic [31:0]          word;
  logic                 hit;
  logic                 miss;
  logic                 store_hit;
  logic                 refill;
  logic                 unused_addr_bits;

  assign idx              = bus.addr[4 +: IDX_W];
  assign tag              = bus.addr[31 -: TAG_W];
  assign offset           = bus.addr[3:2];
  assign unused_addr_bits = ^bus.addr[1:0];
  assign line             = lines[idx];
  assign line_tag         = tags[idx];
  assign word             = line[{offset, 5'b0} +: 32];

  // The stalled request is held stable, so after refill it simply hits again in IDLE.
  assign hit       = (state == IDLE) && bus.is_input_valid && valid[idx] && (line_tag == tag);
  assign miss      = (state == IDLE) && bus.is_input_valid && !hit;
  assign store_hit = hit && bus.mem_rw;
  assign refill    = (state == REFILL_WAIT) && bus.mem_resp_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next          = state;
    bus.is_ready        = 1'b0;
    bus.is_output_valid = 1'b0;
    bus.is_hit          = 1'b0;
    bus.dout            = 32'd0;
    bus.mem_req_valid   = 1'b0;
    bus.mem_req_write   = 1'b0;
    bus.mem_req_addr    = 32'd0;
    bus.mem_req_data    = '0;
    case (state)
      IDLE: begin
        bus.is_ready = 1'b1;
        if (hit) begin
          bus.is_hit          = 1'b1;
          bus.is_output_valid = 1'b1;
          if (!bus.mem_rw) bus.dout = word;
        end else if (miss) begin
          state_next = (valid[idx] && dirty[idx]) ? WRITEBACK : ALLOCATE;
        end
      end
      WRITEBACK: begin
        bus.mem_req_valid = 1'b1;
        bus.mem_req_write = 1'b1;
        bus.mem_req_addr  = {line_tag, idx, 4'b0};
        bus.mem_req_data  = line;
        if (bus.mem_req_ready) state_next = ALLOCATE;
      end
      ALLOCATE: begin
        bus.mem_req_valid = 1'b1;
        bus.mem_req_addr  = {bus.addr[31:4], 4'b0};
        if (bus.mem_req_ready) state_next = REFILL_WAIT;
      end
      REFILL_WAIT: begin
        if (bus.mem_resp_valid) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_count  <= 32'd0;
      miss_count <= 32'd0;
    end else begin
      if (hit)  hit_count  <= hit_count + 32'd1;
      if (miss) miss_count <= miss_count + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= '0;
      dirty <= '0;
    end else begin
      if (store_hit) dirty[idx] <= 1'b1;
      if (refill) begin
        valid[idx] <= 1'b1;
        dirty[idx] <= 1'b0;
      end
    end
  end

  // Tags and data need no reset: a line is only read once its valid bit is set.
  always_ff @(posedge clk) begin
    if (refill) begin
      lines[idx] <= bus.mem_resp_data;
      tags[idx]  <= tag;
    end else if (store_hit) begin
      lines[idx][{offset, 5'b0} +: 32] <= bus.din;
    end
  end
endmodule

// File: tb/tb_data_cache.sv
// Self-checking bench for data_cache: vector table for hits and clean misses, hand
// sequences for dirty write-back, reset mid-refill and counter wrap.
module tb_data_cache;
  localparam int NUM_LINES = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  always #5 clk = ~clk;

  data_cache_if bus ();

  data_cache #(.NUM_LINES(NUM_LINES), .LINE_WORDS(4)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .hit_count(hit_count),
    .miss_count(miss_count)
  );

  typedef struct {
    logic        rw;
    logic [31:0] addr;
    logic [31:0] din;
    logic [31:0] exp_dout;
    int          exp_cycles;
    logic        exp_first_hit;
    int          exp_accepts;
  } vector_t;

  typedef struct {
    logic        chk;
    logic [31:0] dout;
  } expect_t;

  expect_t exp_q[$];
  int vec_count  = 0;
  int fail_count = 0;

  // Backing memory model: ready held low for write-backs by ready_stall cycles,
  // read response pulses resp_latency cycles after acceptance.
  logic [127:0] backing [logic [27:0]];
  int           ready_stall    = 0;
  int           resp_latency   = 3;
  int           resp_countdown = 0;
  int           stall_left     = 0;
  int           req_accepts    = 0;
  int           wait_cycles    = 0;
  int           resp_pulses    = 0;
  bit           snap_valid     = 0;
  bit           unstable       = 0;
  logic [27:0]  pending_line;
  logic [31:0]  snap_addr;
  logic [127:0] snap_data;
  logic         snap_write;
  logic [31:0]  last_rd_addr   = 32'hFFFF_FFFF;
  logic [31:0]  last_wb_addr   = 32'hFFFF_FFFF;
  logic [127:0] last_wb_data   = '0;

  always @(negedge clk) begin
    if (resp_countdown > 0) begin
      resp_countdown     = resp_countdown - 1;
      bus.mem_resp_valid = (resp_countdown == 0);
      bus.mem_resp_data  = backing[pending_line];
      if (resp_countdown == 0) resp_pulses++;
    end else begin
      bus.mem_resp_valid = 1'b0;
      bus.mem_resp_data  = '0;
    end
    if (bus.mem_req_valid) begin
      if (!snap_valid) begin
        snap_valid = 1;
        snap_addr  = bus.mem_req_addr;
        snap_data  = bus.mem_req_data;
        snap_write = bus.mem_req_write;
        stall_left = bus.mem_req_write ? ready_stall : 0;
      end else if (snap_addr !== bus.mem_req_addr || snap_write !== bus.mem_req_write ||
                   (snap_write && snap_data !== bus.mem_req_data)) begin
        unstable = 1;
      end
      if (stall_left > 0) begin
        stall_left        = stall_left - 1;
        wait_cycles++;
        bus.mem_req_ready = 1'b0;
      end else begin
        bus.mem_req_ready = 1'b1;
      end
    end else begin
      bus.mem_req_ready = 1'b0;
    end
  end

  always @(posedge clk) begin
    if (reset) begin
      snap_valid = 0;
    end else if (bus.mem_req_valid && bus.mem_req_ready) begin
      req_accepts++;
      snap_valid = 0;
      if (bus.mem_req_write) begin
        backing[bus.mem_req_addr[31:4]] = bus.mem_req_data;
        last_wb_addr = bus.mem_req_addr;
        last_wb_data = bus.mem_req_data;
      end else begin
        last_rd_addr   = bus.mem_req_addr;
        pending_line   = bus.mem_req_addr[31:4];
        resp_countdown = resp_latency;
      end
    end
  end

  task automatic check_output(input string name, input logic [127:0] actual,
                              input logic [127:0] expected);
    vec_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Called just after a rising edge; returns just after the edge that follows completion.
  task automatic apply_stimulus(input logic rw, input logic [31:0] a, input logic [31:0] d,
                                input logic [31:0] exp_dout, output int cycles,
                                output logic first_hit);
    bit      done;
    expect_t e;
    done      = 0;
    cycles    = 0;
    first_hit = 1'b0;
    exp_q.push_back('{chk: !rw, dout: exp_dout});
    bus.is_input_valid = 1'b1;
    bus.mem_rw         = rw;
    bus.addr           = a;
    bus.din            = d;
    while (!done && cycles < 40) begin
      @(negedge clk);
      cycles++;
      if (cycles == 1) first_hit = bus.is_hit;
      if (bus.is_output_valid) begin
        done = 1;
        if (exp_q.size() == 0) begin
          check_output("scoreboard_empty", 1, 0);
        end else begin
          e = exp_q.pop_front();
          if (e.chk) check_output($sformatf("dout@0x%0h", a), bus.dout, e.dout);
        end
      end
      @(posedge clk);
      #1;
    end
    if (!done) begin
      check_output($sformatf("timeout@0x%0h", a), 0, 1);
      exp_q.delete();
    end
    bus.is_input_valid = 1'b0;
  endtask

  vector_t vecs [8];
  int      cycles;
  logic    first_hit;
  int      base;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got hang, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    backing[28'h004] = {32'd4, 32'd3, 32'd2, 32'd1};
    backing[28'h008] = {32'h2C, 32'h2B, 32'h2A, 32'h29};
    backing[28'h014] = {32'd8, 32'd7, 32'd6, 32'd5};
    backing[28'h01C] = {32'hC4, 32'hC3, 32'hC2, 32'hC1};

    vecs[0] = '{rw: 0, addr: 32'h40, din: 32'h0, exp_dout: 32'd1,  exp_cycles: 6, exp_first_hit: 0, exp_accepts: 1};
    vecs[1] = '{rw: 0, addr: 32'h44, din: 32'h0, exp_dout: 32'd2,  exp_cycles: 1, exp_first_hit: 1, exp_accepts: 1};
    vecs[2] = '{rw: 0, addr: 32'h48, din: 32'h0, exp_dout: 32'd3,  exp_cycles: 1, exp_first_hit: 1, exp_accepts: 1};
    vecs[3] = '{rw: 0, addr: 32'h4C, din: 32'h0, exp_dout: 32'd4,  exp_cycles: 1, exp_first_hit: 1, exp_accepts: 1};
    vecs[4] = '{rw: 1, addr: 32'h48, din: 32'hDEADBEEF, exp_dout: 32'h0, exp_cycles: 1, exp_first_hit: 1, exp_accepts: 1};
    vecs[5] = '{rw: 0, addr: 32'h48, din: 32'h0, exp_dout: 32'hDEADBEEF, exp_cycles: 1, exp_first_hit: 1, exp_accepts: 1};
    vecs[6] = '{rw: 0, addr: 32'h80, din: 32'h0, exp_dout: 32'h29, exp_cycles: 6, exp_first_hit: 0, exp_accepts: 2};
    vecs[7] = '{rw: 0, addr: 32'h8C, din: 32'h0, exp_dout: 32'h2C, exp_cycles: 1, exp_first_hit: 1, exp_accepts: 2};

    reset              = 1'b1;
    bus.is_input_valid = 1'b0;
    bus.mem_rw         = 1'b0;
    bus.addr           = 32'h0;
    bus.din            = 32'h0;
    #3;
    check_output("rst_is_ready", bus.is_ready, 1);
    check_output("rst_mem_req_valid", bus.mem_req_valid, 0);
    check_output("rst_is_output_valid", bus.is_output_valid, 0);
    check_output("rst_dout", bus.dout, 0);
    check_output("rst_is_hit", bus.is_hit, 0);
    check_output("rst_hit_count", hit_count, 0);
    check_output("rst_miss_count", miss_count, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      apply_stimulus(vecs[i].rw, vecs[i].addr, vecs[i].din, vecs[i].exp_dout, cycles, first_hit);
      check_output($sformatf("vec%0d_cycles", i), cycles, vecs[i].exp_cycles);
      check_output($sformatf("vec%0d_first_hit", i), first_hit, vecs[i].exp_first_hit);
      check_output($sformatf("vec%0d_mem_accepts", i), req_accepts, vecs[i].exp_accepts);
      if (i == 0) check_output("alloc_addr_0x40", last_rd_addr, 32'h40);
    end
    check_output("table_hit_count", hit_count, 8);
    check_output("table_miss_count", miss_count, 2);
    check_output("alloc_addr_0x80", last_rd_addr, 32'h80);

    // Dirty victim at index 4: write-back with ready held low two cycles, then allocate.
    ready_stall = 2;
    base        = wait_cycles;
    apply_stimulus(0, 32'h140, 32'h0, 32'd5, cycles, first_hit);
    ready_stall = 0;
    check_output("dirty_cycles", cycles, 9);
    check_output("dirty_first_hit", first_hit, 0);
    check_output("wb_addr", last_wb_addr, 32'h40);
    check_output("wb_data", last_wb_data, {32'd4, 32'hDEADBEEF, 32'd2, 32'd1});
    check_output("wb_ready_low_cycles", wait_cycles - base, 2);
    check_output("wb_req_stable", unstable, 0);
    check_output("alloc_addr_0x140", last_rd_addr, 32'h140);
    check_output("dirty_miss_count", miss_count, 3);
    check_output("dirty_hit_count", hit_count, 9);

    // The written-back store must come back when the old line is refilled.
    apply_stimulus(0, 32'h48, 32'h0, 32'hDEADBEEF, cycles, first_hit);
    check_output("refetch_cycles", cycles, 6);
    check_output("refetch_accepts", req_accepts, 5);

    // Reset while waiting for a refill; the late response must be ignored.
    resp_latency       = 4;
    base               = req_accepts;
    bus.is_input_valid = 1'b1;
    bus.mem_rw         = 1'b0;
    bus.addr           = 32'h1C0;
    for (int i = 0; i < 10 && req_accepts == base; i++) begin
      @(posedge clk);
      #1;
    end
    check_output("abort_in_refill_is_ready", bus.is_ready, 0);
    reset              = 1'b1;
    bus.is_input_valid = 1'b0;
    #1;
    check_output("abort_rst_is_ready", bus.is_ready, 1);
    check_output("abort_rst_hit_count", hit_count, 0);
    check_output("abort_rst_miss_count", miss_count, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    base  = resp_pulses;
    for (int i = 0; i < 12 && resp_pulses == base; i++) begin
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    check_output("stale_resp_pulsed", resp_pulses - base, 1);
    check_output("stale_resp_is_ready", bus.is_ready, 1);
    check_output("stale_resp_hit_count", hit_count, 0);
    check_output("stale_resp_miss_count", miss_count, 0);
    resp_latency = 3;
    apply_stimulus(0, 32'h40, 32'h0, 32'd1, cycles, first_hit);
    check_output("post_rst_first_hit", first_hit, 0);
    check_output("post_rst_cycles", cycles, 6);
    check_output("post_rst_miss_count", miss_count, 1);
    check_output("post_rst_hit_count", hit_count, 1);

    // Counter wrap.
    force dut.hit_count = 32'hFFFF_FFFF;
    #2;
    release dut.hit_count;
    check_output("wrap_preload", hit_count, 32'hFFFF_FFFF);
    apply_stimulus(0, 32'h44, 32'h0, 32'd2, cycles, first_hit);
    check_output("wrap_hit_count", hit_count, 0);
    check_output("wrap_miss_count", miss_count, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, fail_count);
    $finish;
  end
endmodule
